// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV64M multiply/divide unit for the EX stage
//
// Multiplication is shift-add and division is restoring. Each one retires
// one bit per cycle. Operands are captured from ID/EX when start_i is
// accepted, and busy_o holds ID/EX while the unit works.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start_i            M-extension instruction present in ID/EX
//   mdu_op_i           funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   word_intercept_i   W variant (32-bit op, sign-extended result)
//   op_num1_i/2_i      rs1 / rs2 operands
//   addr_rd_i          destination register
//   flush_i            aborts the operation in flight
//   busy_o             stall request (ID/EX hold_n = ~busy_o)
//   result_o           registered result, held until the next completion
//   result_valid_o     one-cycle strobe for result_o / addr_rd_o
//   addr_rd_o          rd captured at start
module ex_muldiv #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      mdu_op_i,
    input  logic            word_intercept_i,
    input  logic [XLEN-1:0] op_num1_i,
    input  logic [XLEN-1:0] op_num2_i,
    input  logic [4:0]      addr_rd_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic [XLEN-1:0] result_o,
    output logic            result_valid_o,
    output logic [4:0]      addr_rd_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [CNT_W-1:0] C_LAST_W = CNT_W'(31);
    localparam logic [CNT_W-1:0] C_LAST_D = CNT_W'(XLEN - 1);

    // Most-negative dividend after operand extension (64-bit and word forms)
    localparam logic [XLEN-1:0] C_MIN_D = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] C_MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic              r_word;
    logic              r_neg1;
    logic              r_neg2;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_result;

    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] r_mcnd;
    logic [XLEN-1:0]   r_mplr;

    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_dvsr;

    // ---------------------------------------------------------------
    // Operand decode at accept
    // ---------------------------------------------------------------
    logic [2:0]      w_op;
    logic            w_is_div;
    logic            w_s1;
    logic            w_s2;
    logic [XLEN-1:0] w_ext1;
    logic [XLEN-1:0] w_ext2;
    logic            w_neg1;
    logic            w_neg2;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_spec_raw;
    logic [XLEN-1:0] w_spec_res;

    // Word forms of MULH/MULHSU/MULHU do not exist; they collapse onto MULW.
    // MUL itself is run unsigned because the low half of the product does
    // not depend on operand signedness.
    assign w_op     = (word_intercept_i && !mdu_op_i[2]) ? OP_MUL : mdu_op_i;
    assign w_is_div = w_op[2];
    assign w_s1     = (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                      (w_op == OP_DIV)  || (w_op == OP_REM);
    assign w_s2     = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);

    always_comb begin
        w_ext1 = op_num1_i;
        w_ext2 = op_num2_i;
        if (word_intercept_i) begin
            w_ext1 = {{(XLEN-32){w_s1 & op_num1_i[31]}}, op_num1_i[31:0]};
            w_ext2 = {{(XLEN-32){w_s2 & op_num2_i[31]}}, op_num2_i[31:0]};
        end
    end

    assign w_neg1 = w_s1 & w_ext1[XLEN-1];
    assign w_neg2 = w_s2 & w_ext2[XLEN-1];
    assign w_mag1 = w_neg1 ? ('0 - w_ext1) : w_ext1;
    assign w_mag2 = w_neg2 ? ('0 - w_ext2) : w_ext2;

    // Division special cases complete in one cycle without iterating
    assign w_div_zero = w_is_div && (w_ext2 == '0);
    assign w_ovf      = w_is_div && !w_op[0] && (w_ext2 == '1) &&
                        (w_ext1 == (word_intercept_i ? C_MIN_W : C_MIN_D));
    assign w_special  = w_div_zero || w_ovf;

    // op[1] selects REM/REMU over DIV/DIVU
    always_comb begin
        w_spec_raw = w_ext1;
        if (w_div_zero) begin
            w_spec_raw = w_op[1] ? w_ext1 : '1;
        end else begin
            w_spec_raw = w_op[1] ? '0 : w_ext1;
        end
    end

    assign w_spec_res = word_intercept_i ?
                        {{(XLEN-32){w_spec_raw[31]}}, w_spec_raw[31:0]} : w_spec_raw;

    // ---------------------------------------------------------------
    // Per-cycle datapath steps
    // ---------------------------------------------------------------
    logic [2*XLEN-1:0] w_acc_next;
    logic [XLEN:0]     w_rem_sh;
    logic              w_ge;
    logic [XLEN-1:0]   w_rem_next;
    logic [XLEN-1:0]   w_quo_next;
    logic              w_last;

    assign w_acc_next = r_mplr[0] ? (r_acc + r_mcnd) : r_acc;

    // Restoring step. The dividend bits stream out of the top of r_quo
    // while quotient bits enter at the bottom. When rem >= divisor, the
    // true difference is below the divisor, so an XLEN-bit subtract is exact.
    assign w_rem_sh   = {r_rem, r_quo[XLEN-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_dvsr});
    assign w_rem_next = w_ge ? (w_rem_sh[XLEN-1:0] - r_dvsr) : w_rem_sh[XLEN-1:0];
    assign w_quo_next = {r_quo[XLEN-2:0], w_ge};

    assign w_last = (r_cnt == (r_word ? C_LAST_W : C_LAST_D));

    // ---------------------------------------------------------------
    // Final sign fix and word extension, applied to the last-step values
    // so that result_o loads on the same edge that enters DONE
    // ---------------------------------------------------------------
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_calc_raw;
    logic [XLEN-1:0]   w_calc_res;

    assign w_prod_fix = (r_neg1 ^ r_neg2) ? ('0 - w_acc_next) : w_acc_next;
    assign w_quo_fix  = (r_neg1 ^ r_neg2) ? ('0 - w_quo_next) : w_quo_next;
    assign w_rem_fix  = r_neg1 ? ('0 - w_rem_next) : w_rem_next;

    always_comb begin
        w_calc_raw = w_prod_fix[XLEN-1:0];
        case (r_op)
            OP_MUL:                       w_calc_raw = w_prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_calc_raw = w_prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_calc_raw = w_quo_fix;
            default:                      w_calc_raw = w_rem_fix;
        endcase
    end

    assign w_calc_res = r_word ? {{(XLEN-32){w_calc_raw[31]}}, w_calc_raw[31:0]} : w_calc_raw;

    // ---------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_word   <= 1'b0;
            r_neg1   <= 1'b0;
            r_neg2   <= 1'b0;
            r_rd     <= '0;
            r_result <= '0;
            r_acc    <= '0;
            r_mcnd   <= '0;
            r_mplr   <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvsr   <= '0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_op   <= w_op;
                        r_word <= word_intercept_i;
                        r_neg1 <= w_neg1;
                        r_neg2 <= w_neg2;
                        r_rd   <= addr_rd_i;
                        r_cnt  <= '0;
                        r_acc  <= '0;
                        r_mcnd <= {{XLEN{1'b0}}, w_mag1};
                        r_mplr <= w_mag2;
                        // A word dividend is left-aligned so that the first
                        // 32 steps consume exactly its 32 significant bits
                        r_quo  <= word_intercept_i ?
                                  {w_mag1[31:0], {(XLEN-32){1'b0}}} : w_mag1;
                        r_rem  <= '0;
                        r_dvsr <= w_mag2;
                        if (w_special) begin
                            r_result <= w_spec_res;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_acc  <= w_acc_next;
                    r_mcnd <= r_mcnd << 1;
                    r_mplr <= r_mplr >> 1;
                    r_quo  <= w_quo_next;
                    r_rem  <= w_rem_next;
                    if (w_last) begin
                        r_result <= w_calc_res;
                        r_cnt    <= '0;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o         = ((r_state == S_IDLE) && start_i) || (r_state == S_CALC);
    assign result_valid_o = (r_state == S_DONE);
    assign result_o       = r_result;
    assign addr_rd_o      = r_rd;

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV64M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes ALU operands, rd address and M-extension op code from ID/EX.
- Raises busy_o while computing. The top level ties ID/EX hold_n = ~busy_o, so the instruction stays parked in ID/EX until the result is ready.
- Registered result plus a one-cycle valid strobe feed the EX/MEM writeback mux.

Parameters:
- XLEN, 64, operand and result width.
- CNT_W, 7, iteration counter width; must hold the value XLEN.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  M-extension instruction present in ID/EX.
- mdu_op_i  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- word_intercept_i  input  1  W variant (32-bit op, sign-extended result).
- op_num1_i  input  XLEN  rs1 operand (dividend / multiplicand).
- op_num2_i  input  XLEN  rs2 operand (divisor / multiplier).
- addr_rd_i  input  5  destination register.
- flush_i  input  1  pipeline flush (trap/branch); aborts the operation.
- busy_o  output  1  stall request; drives ID/EX hold_n low.
- result_o  output  XLEN  registered result.
- result_valid_o  output  1  one-cycle strobe; result_o and addr_rd_o are valid.
- addr_rd_o  output  5  rd captured at start.

Behaviour:
- Reset: all state asynchronously cleared. State IDLE, result_o=0, result_valid_o=0, addr_rd_o=0, busy_o=0.
- States:
  - IDLE to CALC on start_i when the op is not a special case.
  - IDLE to DONE on start_i when the op is a special case.
  - CALC to DONE when the counter reaches N-1.
  - DONE to IDLE unconditionally.
- busy_o = (IDLE & start_i) | CALC. This is combinational, so the stall takes effect in the same cycle start_i rises. busy_o is 0 in DONE, which lets ID/EX advance.
- start_i is ignored in DONE and CALC. During DONE, ID/EX still holds the completing instruction.
- On accept in IDLE, capture op, word flag, rd and operands:
  - W ops: take operands [31:0], then sign-extend (signed ops) or zero-extend (unsigned ops) to XLEN.
  - Signed operands are converted to magnitudes; the result-sign flags are recorded.
- Iteration count N = XLEN (64), or 32 when word_intercept_i=1. One bit per cycle.
- Multiply: shift-add into a 2*XLEN accumulator.
  - MUL returns low XLEN bits.
  - MULH, MULHSU and MULHU return high XLEN bits, with signed correction by negating the full 2*XLEN product.
  - MULHSU: rs1 signed, rs2 unsigned.
  - Word with mdu_op 001–011 is not a legal encoding; it is treated as MULW.
- Divide: restoring division, one quotient bit per cycle.
  - Quotient sign = sign1 ^ sign2.
  - Remainder sign = sign of dividend.
- Special cases take 1-cycle latency and bypass CALC:
  - Divisor (after W truncation) = 0: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - Signed overflow (dividend most-negative, divisor -1, DIV/REM): quotient = dividend, remainder 0.
- W results are sign-extended from bit 31, including DIVUW/REMUW.
- Sign fix and W extension are applied when loading result_o on entry to DONE. result_valid_o=1 only in DONE.
- Latency, with start_i first high in cycle 0:
  - Normal op: busy_o high cycles 0..N; result_valid_o high in cycle N+1 (cycle 65 for 64-bit, cycle 33 for W).
  - Special case: busy_o high cycle 0 only; result_valid_o in cycle 1.
- result_o holds its value after DONE until the next completion.
- flush_i has priority over everything. It forces IDLE on the next edge and clears the counter; busy_o drops that edge. No result_valid_o is issued for the aborted op, and result_o is unchanged.
- flush_i together with start_i in IDLE: the op is not accepted.
- Reset mid-CALC: immediate return to IDLE, outputs zeroed.
- Back-to-back M ops: the second start_i is seen in IDLE the cycle after DONE and accepted normally.

Test Plan:
- MUL 0x7 * 0x6, rd=5 → busy_o high 65 cycles; cycle 65 result_valid_o=1, result_o=0x2A, addr_rd_o=5.
- MULH with op1=-1 (all ones), op2=-1 → result 0x0. MULHU with the same operands → 0xFFFF_FFFF_FFFF_FFFE. MULHSU op1=-2, op2=3 → all ones.
- DIV -7/2 → quotient 0xFFFF_FFFF_FFFF_FFFD (-3); REM -7/2 → -1. DIVUW op1=0xFFFF_FFFF, op2=2 → 0x7FFF_FFFF, valid in cycle 33.
- DIVU x/0 → all ones, REM 13/0 → 13; DIV 0x8000_0000_0000_0000 / -1 → same value, REM → 0. All four: valid in cycle 1, busy_o for one cycle only.
- flush_i asserted in cycle 20 of a DIV → busy_o low from cycle 21, no result_valid_o, result_o keeps its previous value. rst_n pulsed mid-CALC → all outputs 0 asynchronously.
- Two MULs back-to-back (start_i held, ID/EX advancing on DONE) → two valid strobes 66 cycles apart, correct rd on each.
